// File: rtl/sensors_intf_nios2_qsys_0_oci_dct_pkg.sv
// Shared types and sizes for the OCI debug-capture-trace (DCT) sequencer.
//   dct_state_e      : controller states, 3-bit encoding
//   FRAME_W          : width of one trace frame
//   FRAMES_PER_WORD  : frames packed into one dct_buffer word
//   DCT_W            : packed word width (FRAME_W * FRAMES_PER_WORD)
//   CNT_W            : dct_count width, wide enough to hold FRAMES_PER_WORD
package sensors_intf_nios2_qsys_0_oci_dct_pkg;

   localparam int FRAME_W         = 10;
   localparam int FRAMES_PER_WORD = 3;
   localparam int DCT_W           = FRAME_W * FRAMES_PER_WORD;
   localparam int CNT_W           = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_EMIT    = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DONE    = 3'd4
   } dct_state_e;

endpackage

// File: rtl/sensors_intf_nios2_qsys_0_oci_dct_pack.sv
// Slot-write packing register for the DCT buffer.
//   clk, reset_n   : clock, async active-low reset
//   wr_en          : write wr_data into slot dct_count, then increment dct_count
//   clr            : clear the packed word and the frame count
//   wr_data        : frame payload
//   dct_buffer     : packed word, slot k at bits [k*FRAME_W +: FRAME_W]
//   dct_count      : frames held (doubles as the next slot index)
//   full_next      : the next write completes the word
module sensors_intf_nios2_qsys_0_oci_dct_pack
   import sensors_intf_nios2_qsys_0_oci_dct_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_en,
   input  logic               clr,
   input  logic [FRAME_W-1:0] wr_data,
   output logic [DCT_W-1:0]   dct_buffer,
   output logic [CNT_W-1:0]   dct_count,
   output logic               full_next
);

   logic [DCT_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (clr) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (wr_en) begin
         for (int k = 0; k < FRAMES_PER_WORD; k++) begin
            if (cnt_q == CNT_W'(k)) buf_d[k*FRAME_W +: FRAME_W] = wr_data;
         end
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign dct_buffer = buf_q;
   assign dct_count  = cnt_q;
   assign full_next  = (cnt_q == CNT_W'(FRAMES_PER_WORD - 1));

endmodule

// File: rtl/sensors_intf_nios2_qsys_0_oci_dct_ctrl.sv
// OCI DCT sequencer: packs trace frames into dct_buffer, offers full or flushed
// words to the trace sink over valid/ready, and runs the end-of-test flush.
//   clk, reset_n               : clock, async active-low reset
//   arm                        : start/restart capture (honoured in IDLE and DONE)
//   frm_valid/frm_data/frm_ready : trace frame input handshake
//   dct_buffer, dct_count      : packed word and frames held
//   word_valid/word_ready      : word output handshake
//   test_ending                : level request to stop and flush
//   test_has_ended             : flush complete, sticky until arm
//   busy                       : capture, emit or flush in progress
//   word_cnt (DCT_WORD_COUNT_EN only) : accepted words since arm, saturating
//
// state   | meaning
// IDLE    | waiting for arm
// CAPTURE | accepting frames into the packing register
// EMIT    | full word offered, waiting for word_ready
// FLUSH   | partial word offered (if any), then finish
// DONE    | flush complete, test_has_ended asserted
module sensors_intf_nios2_qsys_0_oci_dct_ctrl
   import sensors_intf_nios2_qsys_0_oci_dct_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               arm,
   input  logic               frm_valid,
   input  logic [FRAME_W-1:0] frm_data,
   output logic               frm_ready,
   output logic [DCT_W-1:0]   dct_buffer,
   output logic [CNT_W-1:0]   dct_count,
   output logic               word_valid,
   input  logic               word_ready,
   input  logic               test_ending,
   output logic               test_has_ended,
`ifdef DCT_WORD_COUNT_EN
   output logic [15:0]        word_cnt,
`endif
   output logic               busy
);

   dct_state_e state_q, state_d;
   logic flush_pend_q, flush_pend_d;
   logic frm_ready_q, frm_ready_d;
   logic word_valid_q, word_valid_d;
   logic test_has_ended_q, test_has_ended_d;
   logic busy_q, busy_d;

   logic             pk_wr, pk_clr, pk_full_next;
   logic [CNT_W-1:0] pk_cnt;
   logic             frm_acc, wd_acc, arm_take;

   sensors_intf_nios2_qsys_0_oci_dct_pack u_pack (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (pk_wr),
      .clr        (pk_clr),
      .wr_data    (frm_data),
      .dct_buffer (dct_buffer),
      .dct_count  (pk_cnt),
      .full_next  (pk_full_next)
   );

   assign frm_acc  = frm_ready_q & frm_valid;
   assign wd_acc   = word_valid_q & word_ready;
   assign arm_take = arm & ((state_q == ST_IDLE) | (state_q == ST_DONE));

   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      word_valid_d = 1'b0;
      pk_wr        = 1'b0;
      pk_clr       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            flush_pend_d = 1'b0;
            if (arm) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            pk_wr = frm_acc;
            if (frm_acc && pk_full_next) begin
               // a frame that fills the word takes priority; the flush waits behind it
               state_d      = ST_EMIT;
               word_valid_d = 1'b1;
               flush_pend_d = test_ending;
            end else if (test_ending) begin
               state_d      = ST_FLUSH;
               word_valid_d = frm_acc | (pk_cnt != '0);
            end
         end
         ST_EMIT: begin
            if (wd_acc) begin
               pk_clr       = 1'b1;
               flush_pend_d = 1'b0;
               state_d      = (flush_pend_q | test_ending) ? ST_FLUSH : ST_CAPTURE;
            end else begin
               word_valid_d = 1'b1;
               if (test_ending) flush_pend_d = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (pk_cnt == '0) begin
               state_d = ST_DONE;
            end else if (wd_acc) begin
               pk_clr  = 1'b1;
               state_d = ST_DONE;
            end else begin
               word_valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (arm) state_d = ST_CAPTURE;
         end
         default: state_d = ST_IDLE;
      endcase
      frm_ready_d      = (state_d == ST_CAPTURE);
      test_has_ended_d = (state_d == ST_DONE);
      busy_d           = (state_d != ST_IDLE) && (state_d != ST_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         flush_pend_q     <= 1'b0;
         frm_ready_q      <= 1'b0;
         word_valid_q     <= 1'b0;
         test_has_ended_q <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         flush_pend_q     <= flush_pend_d;
         frm_ready_q      <= frm_ready_d;
         word_valid_q     <= word_valid_d;
         test_has_ended_q <= test_has_ended_d;
         busy_q           <= busy_d;
      end
   end

`ifdef DCT_WORD_COUNT_EN
   logic [15:0] word_cnt_q, word_cnt_d;

   always_comb begin
      word_cnt_d = word_cnt_q;
      if (arm_take) word_cnt_d = '0;
      else if (wd_acc && word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) word_cnt_q <= '0;
      else          word_cnt_q <= word_cnt_d;
   end

   assign word_cnt = word_cnt_q;
`else
   logic unused_arm_take;
   assign unused_arm_take = arm_take;
`endif

   assign frm_ready      = frm_ready_q;
   assign dct_count      = pk_cnt;
   assign word_valid     = word_valid_q;
   assign test_has_ended = test_has_ended_q;
   assign busy           = busy_q;

endmodule
